stoch_sat_arith_lanes: RTL

//  Multi-lane stochastic saturating add/subtract. Per lane, a run-time mode

---
 rtl/stoch_sat_arith_lanes.sv | 105 ++++++++++
 1 files changed

// File: rtl/stoch_sat_arith_lanes.sv
`default_nettype none
// ============================================================================
// Module      : stoch_sat_arith_lanes
// Description : Multi-lane stochastic saturating add/subtract on unipolar
//               bitstreams. Each lane runs as SUB, y = max(a-b, 0), or as
//               ADD, y = min(a+b, 1). A per-lane saturating counter holds the
//               deferred events. The y and sat outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module stoch_sat_arith_lanes #(
  parameter int LANES        = 4,
  parameter int COUNTER_SIZE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic [LANES-1:0] mode,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] sat
);

  localparam logic [COUNTER_SIZE-1:0] c_MAX  = {COUNTER_SIZE{1'b1}};
  localparam logic [COUNTER_SIZE-1:0] c_ZERO = {COUNTER_SIZE{1'b0}};
  localparam logic [COUNTER_SIZE-1:0] c_ONE  = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

  localparam logic c_MODE_SUB = 1'b0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // The counter means b-debt in SUB and output credit in ADD.
    logic [COUNTER_SIZE-1:0] r_cnt;
    logic                    r_y;
    logic                    r_sat;
    logic                    r_mode_q;
    logic                    w_cnt_zero;
    logic                    w_cnt_max;

    assign w_cnt_zero = (r_cnt == c_ZERO);
    assign w_cnt_max  = (r_cnt == c_MAX);

    // Per-lane state update. Priority is reset, then clear, then enabled advance.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_cnt    <= c_ZERO;
        r_y      <= 1'b0;
        r_sat    <= 1'b0;
        r_mode_q <= 1'b0;
      end else if (clr) begin
        r_cnt    <= c_ZERO;
        r_y      <= 1'b0;
        r_sat    <= 1'b0;
        r_mode_q <= mode[i];
      end else if (en) begin
        if (mode[i] != r_mode_q) begin
          // The deferred events belong to the old operation, so they are
          // dropped. This cycle's a/b are also dropped.
          r_cnt    <= c_ZERO;
          r_y      <= 1'b0;
          r_mode_q <= mode[i];
        end else if (r_mode_q == c_MODE_SUB) begin
          case ({a[i], b[i]})
            2'b10: begin
              if (w_cnt_zero) begin
                r_y <= 1'b1;
              end else begin
                r_y   <= 1'b0;
                r_cnt <= r_cnt - c_ONE;
              end
            end
            2'b01: begin
              r_y <= 1'b0;
              if (w_cnt_max) r_sat <= 1'b1;
              else           r_cnt <= r_cnt + c_ONE;
            end
            default: r_y <= 1'b0;
          endcase
        end else begin
          case ({a[i], b[i]})
            2'b11: begin
              r_y <= 1'b1;
              if (w_cnt_max) r_sat <= 1'b1;
              else           r_cnt <= r_cnt + c_ONE;
            end
            2'b00: begin
              if (w_cnt_zero) begin
                r_y <= 1'b0;
              end else begin
                r_y   <= 1'b1;
                r_cnt <= r_cnt - c_ONE;
              end
            end
            default: r_y <= 1'b1;
          endcase
        end
      end
    end

    assign y[i]   = r_y;
    assign sat[i] = r_sat;
  end

endmodule
`default_nettype wire
